// File: rtl/instr_prefetch_mem.sv
// Instruction memory with a sequential fetch engine feeding a small prefetch FIFO.
// Streams {pc, instr} pairs to decode over valid/ready; supports redirect, HALT and program load.
module instr_prefetch_mem #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter int                OPC_W      = 4,
  parameter logic [OPC_W-1:0]  HALT_OP    = 4'b1111,
  parameter                    INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [2**ADDR_W];
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  held_instr;
  logic [ADDR_W-1:0]  held_pc;
  logic               pop;
  logic               issue;
  logic               is_halt;
  logic [ADDR_W-1:0]  pc_next;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign issue       = (state == FETCH) & en & ~load_en & ~redirect &
                       ((count < CNT_W'(FIFO_DEPTH)) | pop);
  assign is_halt     = (rd_data[DATA_W-1 -: OPC_W] == HALT_OP);

  // An empty FIFO keeps showing the last head rather than a stale slot.
  assign instr    = instr_valid ? fifo_instr[rd_ptr] : held_instr;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr]    : held_pc;

  always_comb begin
    pc_next = fetch_pc;
    if (redirect)
      pc_next = redirect_pc;
    else if (issue)
      pc_next = fetch_pc + 1'b1;
  end

  // Read is addressed with next cycle's fetch_pc, so rd_data always holds mem[fetch_pc].
  // A load to that same address is forwarded so the following issue sees the new word.
  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_addr] <= load_data;
    rd_data <= (load_en && (load_addr == pc_next)) ? load_data : mem[pc_next];
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      fifo_instr[wr_ptr] <= rd_data;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= '0;
      halted     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      held_instr <= '0;
      held_pc    <= '0;
    end else begin
      fetch_pc <= pc_next;
      if (instr_valid) begin
        held_instr <= fifo_instr[rd_ptr];
        held_pc    <= fifo_pc[rd_ptr];
      end
      if (redirect) begin
        state  <= FETCH;
        halted <= 1'b0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (issue) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (is_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({issue, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_mem.sv
// Directed bench for instr_prefetch_mem: streaming, backpressure, redirect, HALT, wrap, load, reset.
module tb_instr_prefetch_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] fetch_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instr_prefetch_mem dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .fetch_pc(fetch_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    tick;
    redirect = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; instr_ready = 1'b0;
    repeat (2) tick;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", instr_valid); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got %h expected 0000", instr); end
    checks++; if (instr_pc !== 16'h0) begin errors++; $display("FAIL reset_instr_pc got %h expected 0000", instr_pc); end
    checks++; if (fetch_pc !== 16'h0) begin errors++; $display("FAIL reset_fetch_pc got %h expected 0000", fetch_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", halted); end
    rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
    repeat (3) tick;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_no_issue got %b expected 0", instr_valid); end
    checks++; if (fetch_pc !== 16'h0) begin errors++; $display("FAIL idle_fetch_pc got %h expected 0000", fetch_pc); end
  endtask

  task automatic load_program;
    logic [15:0] a;
    logic [15:0] d;
    load_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < 32)      a = 16'(i);
      else if (i < 48) a = 16'h0100 + 16'(i - 32);
      else             a = 16'hFFF0 + 16'(i - 48);
      case (a)
        16'h0000: d = 16'h5104;
        16'h0001: d = 16'h5205;
        16'h0002: d = 16'h5306;
        16'h0003: d = 16'h0123;
        16'h0010: d = 16'hF000;
        default:  d = 16'h5000 | (a & 16'h0FFF);
      endcase
      load_addr = a; load_data = d;
      tick;
    end
    load_en = 1'b0;
  endtask

  task automatic test_stream;
    logic [15:0] exp_instr [4];
    exp_instr[0] = 16'h5104; exp_instr[1] = 16'h5205;
    exp_instr[2] = 16'h5306; exp_instr[3] = 16'h0123;
    instr_ready = 1'b1;
    do_redirect(16'h0000);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got %b expected 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      tick;
      $display("xfer valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'(i)) begin
        errors++; $display("FAIL stream_pc got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, 16'(i)); end
      checks++; if (instr !== exp_instr[i]) begin
        errors++; $display("FAIL stream_instr got %h expected %h", instr, exp_instr[i]); end
    end
  endtask

  task automatic test_backpressure;
    instr_ready = 1'b0;
    do_redirect(16'h0000);
    repeat (6) tick;
    checks++; if (fetch_pc !== 16'h0004) begin errors++; $display("FAIL bp_fetch_stall got %h expected 0004", fetch_pc); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
      errors++; $display("FAIL bp_head got v=%b pc=%h expected v=1 pc=0000", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      $display("xfer valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'(i)) begin
        errors++; $display("FAIL bp_order got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, 16'(i)); end
      tick;
    end
  endtask

  task automatic test_redirect;
    instr_ready = 1'b0;
    do_redirect(16'h0000);
    repeat (3) tick;
    checks++; if (fetch_pc !== 16'h0003) begin errors++; $display("FAIL redir_queued got %h expected 0003", fetch_pc); end
    instr_ready = 1'b1;
    do_redirect(16'h0100);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b expected 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      tick;
      $display("xfer valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL redir_pc got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, 16'h0100 + 16'(i)); end
    end
  endtask

  task automatic test_halt;
    instr_ready = 1'b1;
    do_redirect(16'h000E);
    for (int i = 0; i < 3; i++) begin
      tick;
      $display("xfer valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h000E + 16'(i)) begin
        errors++; $display("FAIL halt_seq got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, 16'h000E + 16'(i)); end
      checks++; if (halted !== (i == 2)) begin errors++; $display("FAIL halt_flag got %b expected %b", halted, (i == 2)); end
    end
    checks++; if (instr !== 16'hF000) begin errors++; $display("FAIL halt_word got %h expected f000", instr); end
    repeat (3) tick;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_stop got %b expected 0", instr_valid); end
    checks++; if (halted !== 1'b1 || fetch_pc !== 16'h0011) begin
      errors++; $display("FAIL halt_hold got h=%b pc=%h expected h=1 pc=0011", halted, fetch_pc); end
    do_redirect(16'h0000);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b expected 0", halted); end
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
      errors++; $display("FAIL halt_resume got v=%b pc=%h expected v=1 pc=0000", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
    instr_ready = 1'b1;
    do_redirect(16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick;
      $display("xfer valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i]) begin
        errors++; $display("FAIL wrap_pc got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, exp_pc[i]); end
    end
  endtask

  task automatic test_load_and_async_reset;
    instr_ready = 1'b1;
    do_redirect(16'h0000);
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
      errors++; $display("FAIL load_first got v=%b pc=%h expected v=1 pc=0000", instr_valid, instr_pc); end
    load_en = 1'b1; load_addr = 16'h0005; load_data = 16'hABCD;
    tick;
    load_en = 1'b0;
    checks++; if (instr_valid !== 1'b0 || fetch_pc !== 16'h0001) begin
      errors++; $display("FAIL load_bubble got v=%b pc=%h expected v=0 pc=0001", instr_valid, fetch_pc); end
    for (int p = 1; p <= 5; p++) begin
      tick;
      $display("xfer valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'(p)) begin
        errors++; $display("FAIL load_seq got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, 16'(p)); end
    end
    checks++; if (instr !== 16'hABCD) begin errors++; $display("FAIL load_data got %h expected abcd", instr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || fetch_pc !== 16'h0) begin
      errors++; $display("FAIL async_rst got v=%b pc=%h expected v=0 pc=0000", instr_valid, fetch_pc); end
    checks++; if (instr_pc !== 16'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL async_rst_out got pc=%h h=%b expected pc=0000 h=0", instr_pc, halted); end
    tick;
    rst = 1'b0;
    repeat (3) tick;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b expected 0", instr_valid); end
  endtask

  initial begin
    test_reset;
    load_program;
    test_stream;
    test_backpressure;
    test_redirect;
    test_halt;
    test_wrap;
    test_load_and_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
